// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: memop encoding, FSM states,
// local exception bit positions and bus size codes.
package mem_access_pkg;

    typedef enum logic [3:0] {
        MemNone = 4'd0,
        MemLb   = 4'd1,
        MemLbu  = 4'd2,
        MemLh   = 4'd3,
        MemLhu  = 4'd4,
        MemLw   = 4'd5,
        MemSb   = 4'd6,
        MemSh   = 4'd7,
        MemSw   = 4'd8
    } memop_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StData  = 3'd2,
        StDone  = 3'd3,
        StDrain = 3'd4
    } state_e;

    localparam int unsigned AdelBit = 4;
    localparam int unsigned AdesBit = 5;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    function automatic logic is_load(memop_e op);
        return (op == MemLb) || (op == MemLbu) || (op == MemLh) ||
               (op == MemLhu) || (op == MemLw);
    endfunction

    function automatic logic is_store(memop_e op);
        return (op == MemSb) || (op == MemSh) || (op == MemSw);
    endfunction

    function automatic logic [1:0] op_size(memop_e op);
        case (op)
            MemLh, MemLhu, MemSh: return SizeHalf;
            MemLw, MemSw:         return SizeWord;
            default:              return SizeByte;
        endcase
    endfunction

    // Byte accesses (and non-memory ops) are always aligned.
    function automatic logic is_aligned(memop_e op, logic [1:0] addr_lo);
        case (op_size(op))
            SizeHalf: return !addr_lo[0];
            SizeWord: return addr_lo == 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational data alignment: store strobes/lane replication and load
// byte/halfword extraction with sign or zero extension.
module mem_align
    import mem_access_pkg::*;
(
    input  memop_e      memop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Store side: strobe and replicate the datum across every lane it may land in.
    always_comb begin
        size  = op_size(memop);
        wstrb = 4'b0000;
        wdata = store_data;
        case (memop)
            MemSb: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MemSh: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            MemSw: wstrb = 4'b1111;
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (memop)
            MemLb:   load_data = {{24{byte_v[7]}}, byte_v};
            MemLbu:  load_data = {24'd0, byte_v};
            MemLh:   load_data = {{16{half_v[15]}}, half_v};
            MemLhu:  load_data = {16'd0, half_v};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage bus master: issues one load/store per instruction on a
// request/response bus, stalls the pipeline while the access is pending and
// delivers load results / exception info toward MEM/WB.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pipe_en,
    input  logic        ex_valid,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_except_in,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_mem_addr,
    output logic [31:0] mem_except_type,
    output logic        stallreq
);

    state_e      state_q;
    memop_e      op_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] data_q;

    memop_e      ex_op;
    logic        ex_is_mem;
    logic        ex_aligned;
    logic        start;

    memop_e      al_op;
    logic [31:0] al_addr;
    logic [31:0] al_sdata;
    logic [31:0] load_data;

    assign ex_op      = memop_e'(ex_memop);
    assign ex_is_mem  = is_load(ex_op) || is_store(ex_op);
    assign ex_aligned = is_aligned(ex_op, ex_mem_addr[1:0]);

    // rst gates start so no request escapes while reset is being applied.
    assign start = (state_q == StIdle) && ex_valid && ex_is_mem &&
                   (ex_except_in == 32'd0) && ex_aligned && !flush && !rst;

    // In the start cycle the request comes straight from EX; afterwards from the
    // latched copy so the bus sees stable values until the address handshake.
    assign al_op    = (state_q == StIdle) ? ex_op         : op_q;
    assign al_addr  = (state_q == StIdle) ? ex_mem_addr   : addr_q;
    assign al_sdata = (state_q == StIdle) ? ex_store_data : sdata_q;

    mem_align u_align (
        .memop      (al_op),
        .addr_lo    (al_addr[1:0]),
        .store_data (al_sdata),
        .rdata      (bus_rdata),
        .size       (bus_size),
        .wstrb      (bus_wstrb),
        .wdata      (bus_wdata),
        .load_data  (load_data)
    );

    assign bus_req  = start || ((state_q == StAddr) && !flush);
    assign bus_wr   = is_store(al_op);
    assign bus_addr = al_addr;

    assign mem_mem_addr = ex_mem_addr;

    // Access FSM plus request/result latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= MemNone;
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= ex_op;
                        addr_q  <= ex_mem_addr;
                        sdata_q <= ex_store_data;
                        state_q <= bus_addr_ok ? StData : StAddr;
                    end
                end
                StAddr: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (bus_addr_ok) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bus_data_ok) begin
                        if (flush || pipe_en) begin
                            state_q <= StIdle;
                        end else begin
                            data_q  <= load_data;
                            state_q <= StDone;
                        end
                    end else if (flush) begin
                        state_q <= StDrain;
                    end
                end
                StDone: begin
                    if (flush || pipe_en) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    // The response to the squashed access must still be consumed.
                    if (bus_data_ok) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Pipeline hold: released in the data_ok cycle so the result moves on at once.
    always_comb begin
        stallreq = 1'b0;
        unique case (state_q)
            StIdle:  stallreq = start;
            StAddr:  stallreq = 1'b1;
            StData:  stallreq = !bus_data_ok;
            StDone:  stallreq = 1'b0;
            StDrain: stallreq = 1'b1;
            default: stallreq = 1'b0;
        endcase
    end

    // Result toward MEM/WB: load data live in the data_ok cycle, latched in DONE.
    always_comb begin
        mem_wdata = ex_wdata;
        if (is_load(op_q)) begin
            if (state_q == StDone) begin
                mem_wdata = data_q;
            end else if (state_q == StData) begin
                mem_wdata = load_data;
            end
        end
    end

    // Merge local address-error bits into the incoming exception vector.
    always_comb begin
        mem_except_type = ex_except_in;
        if (ex_valid && !ex_aligned) begin
            if (is_load(ex_op)) begin
                mem_except_type[AdelBit] = 1'b1;
            end
            if (is_store(ex_op)) begin
                mem_except_type[AdesBit] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: per-cycle expectations for handshake/stall,
// an arithmetic model for bus lanes, load extraction and exceptions, and a
// few literal values that pin the model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, pipe_en, ex_valid;
    logic [3:0]  ex_memop;
    logic [31:0] ex_mem_addr, ex_store_data, ex_wdata, ex_except_in;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic [31:0] mem_wdata, mem_mem_addr, mem_except_type;
    logic        stallreq;

    int checks   = 0;
    int failures = 0;

    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_wv;
    logic [31:0] exp_wdata;

    always #5 clk = ~clk;

    mem_access dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .pipe_en         (pipe_en),
        .ex_valid        (ex_valid),
        .ex_memop        (ex_memop),
        .ex_mem_addr     (ex_mem_addr),
        .ex_store_data   (ex_store_data),
        .ex_wdata        (ex_wdata),
        .ex_except_in    (ex_except_in),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_size        (bus_size),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_addr_ok     (bus_addr_ok),
        .bus_data_ok     (bus_data_ok),
        .bus_rdata       (bus_rdata),
        .mem_wdata       (mem_wdata),
        .mem_mem_addr    (mem_mem_addr),
        .mem_except_type (mem_except_type),
        .stallreq        (stallreq)
    );

    // ---------------- model ----------------
    function automatic int unsigned m_bytes(logic [3:0] op);
        case (op)
            MemLb, MemLbu, MemSb: return 1;
            MemLh, MemLhu, MemSh: return 2;
            MemLw, MemSw:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic logic m_load_op(logic [3:0] op);
        return op == MemLb || op == MemLbu || op == MemLh || op == MemLhu || op == MemLw;
    endfunction

    function automatic logic m_store_op(logic [3:0] op);
        return op == MemSb || op == MemSh || op == MemSw;
    endfunction

    function automatic logic m_misaligned(logic [3:0] op, logic [31:0] addr);
        int unsigned n;
        n = m_bytes(op);
        return (n != 0) && ((addr % n) != 0);
    endfunction

    function automatic logic [31:0] m_load(logic [3:0] op, logic [31:0] addr, logic [31:0] rd);
        int unsigned n, off;
        logic [31:0] mask, v;
        n    = m_bytes(op);
        off  = ((addr % 4) / n) * n;
        v    = rd >> (8 * off);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if ((op == MemLb || op == MemLh) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_strb(logic [3:0] op, logic [31:0] addr);
        int unsigned n, off;
        n   = m_bytes(op);
        off = ((addr % 4) / n) * n;
        return (n == 4) ? 4'hF : 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(logic [3:0] op, logic [31:0] sd);
        int unsigned n;
        n = m_bytes(op);
        if (n == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_except(logic v, logic [3:0] op, logic [31:0] addr,
                                             logic [31:0] exc);
        logic [31:0] e;
        e = exc;
        if (v && m_misaligned(op, addr) && m_load_op(op))  e = e | 32'h10;
        if (v && m_misaligned(op, addr) && m_store_op(op)) e = e | 32'h20;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
            chk("stallreq", {31'd0, stallreq}, {31'd0, exp_stall});
            if (exp_req) begin
                chk("bus_wr", {31'd0, bus_wr}, {31'd0, m_store_op(ex_memop)});
                chk("bus_size", {30'd0, bus_size},
                    (m_bytes(ex_memop) == 1) ? 32'd0 : (m_bytes(ex_memop) == 2) ? 32'd1 : 32'd2);
                chk("bus_addr", bus_addr, ex_mem_addr);
                if (m_store_op(ex_memop)) begin
                    chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, m_strb(ex_memop, ex_mem_addr)});
                    chk("bus_wdata", bus_wdata, m_wdata(ex_memop, ex_store_data));
                end
            end
            chk("mem_mem_addr", mem_mem_addr, ex_mem_addr);
            chk("mem_except_type", mem_except_type,
                m_except(ex_valid, ex_memop, ex_mem_addr, ex_except_in));
            if (exp_wv) chk("mem_wdata", mem_wdata, exp_wdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic req, input logic stall, input logic wv,
                        input logic [31:0] wexp);
        exp_req   = req;
        exp_stall = stall;
        exp_wv    = wv;
        exp_wdata = wexp;
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] wd, input logic [31:0] exc);
        ex_valid      = v;
        ex_memop      = op;
        ex_mem_addr   = addr;
        ex_store_data = sd;
        ex_wdata      = wd;
        ex_except_in  = exc;
    endtask

    // Start cycle with the address accepted immediately.
    task automatic acc_start(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
        set_ex(1'b1, op, addr, sd, 32'h0BAD_0000 | addr, 32'd0);
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    // Data cycle: result is valid right here.
    task automatic acc_data(input logic [31:0] rd);
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        step(1'b0, 1'b0, 1'b1,
             m_load_op(ex_memop) ? m_load(ex_memop, ex_mem_addr, rd) : ex_wdata);
    endtask

    task automatic idle();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        flush       = 1'b0;
        pipe_en     = 1'b1;
        ex_valid    = 1'b0;
        ex_memop    = MemNone;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        adv();
    endtask

    task automatic fast_access(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] sd, input logic [31:0] rd);
        acc_start(op, addr, sd);
        adv();
        acc_data(rd);
    endtask

    logic [31:0] held;

    initial begin
        rst = 1'b1; flush = 1'b0; pipe_en = 1'b1;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_wv = 1'b0; exp_wdata = 32'd0;
        set_ex(1'b1, MemLw, 32'h100, 32'd0, 32'd0, 32'd0);
        adv(); adv();
        // Reset still asserted, after a reset edge, with a startable LW presented.
        @(negedge clk); #1;
        chk("reset bus_req", {31'd0, bus_req}, 32'd0);
        chk("reset stallreq", {31'd0, stallreq}, 32'd0);
        adv();
        rst = 1'b0;
        chk_en = 1'b1;
        idle();

        // Non-memory instruction passes data and exceptions through.
        set_ex(1'b1, MemNone, 32'h40, 32'd0, 32'h5555_AAAA, 32'h3);
        step(1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
        chk("nonmem except", mem_except_type, 32'h3);
        adv();

        // LW minimum latency.
        fast_access(MemLw, 32'h100, 32'd0, 32'hDEAD_BEEF);
        chk("lw result", mem_wdata, 32'hDEAD_BEEF);
        adv(); idle();

        fast_access(MemLb, 32'h103, 32'd0, 32'h80FF_FFFF);
        chk("lb result", mem_wdata, 32'hFFFF_FF80);
        adv(); idle();
        fast_access(MemLbu, 32'h103, 32'd0, 32'h80FF_FFFF);
        chk("lbu result", mem_wdata, 32'h0000_0080);
        adv(); idle();
        fast_access(MemLh, 32'h102, 32'd0, 32'h8001_1234);
        chk("lh result", mem_wdata, 32'hFFFF_8001);
        adv(); idle();
        fast_access(MemLhu, 32'h100, 32'd0, 32'h8001_9234);
        chk("lhu result", mem_wdata, 32'h0000_9234);
        adv(); idle();

        // Stores: lane strobes and replication.
        acc_start(MemSh, 32'h202, 32'h1234_ABCD);
        chk("sh wstrb", {28'd0, bus_wstrb}, 32'hC);
        chk("sh wdata", bus_wdata, 32'hABCD_ABCD);
        chk("sh size", {30'd0, bus_size}, 32'd1);
        chk("sh wr", {31'd0, bus_wr}, 32'd1);
        adv(); acc_data(32'd0); adv(); idle();
        acc_start(MemSb, 32'h201, 32'h0000_00CD);
        chk("sb wstrb", {28'd0, bus_wstrb}, 32'h2);
        chk("sb wdata", bus_wdata, 32'hCDCD_CDCD);
        adv(); acc_data(32'd0); adv(); idle();
        acc_start(MemSw, 32'h204, 32'hCAFE_F00D);
        chk("sw wstrb", {28'd0, bus_wstrb}, 32'hF);
        adv(); acc_data(32'd0); adv(); idle();

        // Misaligned / blocked accesses: no request, no stall.
        set_ex(1'b1, MemLw, 32'h101, 32'd0, 32'h99, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("lw misaligned adel", mem_except_type, 32'h10);
        chk("lw misaligned addr", mem_mem_addr, 32'h101);
        adv();
        set_ex(1'b1, MemSw, 32'h206, 32'h1, 32'h77, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h77);
        chk("sw misaligned ades", mem_except_type, 32'h20);
        adv();
        set_ex(1'b1, MemLh, 32'h103, 32'd0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        adv();
        set_ex(1'b1, MemLw, 32'h100, 32'd0, 32'd0, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        adv();
        set_ex(1'b1, MemLw, 32'h100, 32'd0, 32'd0, 32'd0);
        flush = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        adv(); idle();

        // Slow address handshake, then flush in DATA -> drain.
        set_ex(1'b1, MemLh, 32'h102, 32'd0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0); adv();
        step(1'b1, 1'b1, 1'b0, 32'd0); adv();
        step(1'b1, 1'b1, 1'b0, 32'd0); adv();
        bus_addr_ok = 1'b1;
        step(1'b1, 1'b1, 1'b0, 32'd0); adv();
        bus_addr_ok = 1'b0; flush = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'd0); adv();
        flush = 1'b0; ex_valid = 1'b0; ex_memop = MemNone;
        step(1'b0, 1'b1, 1'b0, 32'd0); adv();
        step(1'b0, 1'b1, 1'b0, 32'd0); adv();
        bus_data_ok = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        step(1'b0, 1'b1, 1'b0, 32'd0); adv();
        idle();

        // data_ok while pipe_en=0 for two cycles -> DONE holds the result.
        acc_start(MemLw, 32'h104, 32'd0);
        adv();
        pipe_en = 1'b0;
        acc_data(32'h1122_3344);
        adv();
        held = m_load(MemLw, 32'h104, 32'h1122_3344);
        bus_data_ok = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        step(1'b0, 1'b0, 1'b1, held);
        chk("done hold", mem_wdata, 32'h1122_3344);
        adv();
        pipe_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, held);
        adv();
        fast_access(MemLbu, 32'h105, 32'd0, 32'h0000_AB00);
        chk("lbu after done", mem_wdata, 32'h0000_00AB);
        adv(); idle();

        // Flush in ADDR drops the request.
        set_ex(1'b1, MemLw, 32'h108, 32'd0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0); adv();
        flush = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'd0); adv();
        idle();

        // Flush together with data_ok (pipe_en low): straight back to IDLE.
        acc_start(MemLw, 32'h10C, 32'd0);
        adv();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        flush = 1'b1; pipe_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'd0); adv();
        flush = 1'b0; pipe_en = 1'b1;
        fast_access(MemSw, 32'h110, 32'h0F0F_0F0F, 32'd0);
        adv(); idle();

        // Flush in DONE.
        acc_start(MemLw, 32'h114, 32'd0);
        adv();
        pipe_en = 1'b0;
        acc_data(32'hAAAA_5555);
        adv();
        bus_data_ok = 1'b0; flush = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'd0); adv();
        flush = 1'b0;
        acc_start(MemLw, 32'h118, 32'd0);
        adv();
        pipe_en = 1'b1;
        acc_data(32'h0102_0304);
        adv(); idle();

        // Reset in ADDR abandons the access without draining.
        set_ex(1'b1, MemLw, 32'h11C, 32'd0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0); adv();
        rst = 1'b1; chk_en = 1'b0;
        adv();
        rst = 1'b0; chk_en = 1'b1;
        idle();
        fast_access(MemLh, 32'h120, 32'd0, 32'h0000_7FFF);
        chk("lh after reset", mem_wdata, 32'h0000_7FFF);
        adv(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
